// File: rtl/srl_pkg.sv
// Shared helpers for the addressable SRL delay line: clog2, default-geometry widths
// and parameter legality.
package srl_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic bit params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 2);
  endfunction

  localparam int DEF_DEPTH = 130;
  localparam int DEF_AW    = clog2(DEF_DEPTH);
  localparam int DEF_CW    = clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/srl_chain.sv
// One-bit resetless shift chain with enable and addressable tap; maps to SRL cascades.
// The caller clamps addr below depth, so the tap index is always in range.
module srl_chain
  import srl_pkg::*;
#(
  parameter int depth = 130,
  localparam int AW = clog2(depth)
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          d,
  input  logic [AW-1:0] addr,
  output logic          tap
);

  // No reset and no initial value: either one would block SRL inference.
  logic [depth-1:0] sr_q;
  logic [depth-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (ce) sr_d = {sr_q[depth-2:0], d};
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign tap = sr_q[addr];

endmodule

// File: rtl/srl_tap_delay.sv
// Addressable multi-bit delay line: resetless SRL storage plus a reset-tracked fill
// counter that flags whether the selected tap holds data shifted in since reset.
module srl_tap_delay
  import srl_pkg::*;
#(
  parameter int width  = 1,
  parameter int depth  = 130,
  parameter bit outreg = 1'b1,
  localparam int AW = clog2(depth),
  localparam int CW = clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             ce,
  input  logic [width-1:0] i,
  input  logic [AW-1:0]    a,
  output logic [width-1:0] q,
  output logic             valid
);

  if (!params_ok(width, depth)) begin : g_bad_params
    $error("srl_tap_delay: need width >= 1 and depth >= 2");
  end

  logic [AW-1:0]    ea;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [width-1:0] tap;
  logic             tap_ok;
  logic             shift_en;

  // Reset beats enable: a reset cycle never shifts the storage.
  assign shift_en = ce & ~r;

  always_comb begin
    ea = a;
    if (a > AW'(depth - 1)) ea = AW'(depth - 1);
  end

  for (genvar b = 0; b < width; b++) begin : g_bit
    srl_chain #(
      .depth(depth)
    ) u_chain (
      .clk (clk),
      .ce  (shift_en),
      .d   (i[b]),
      .addr(ea),
      .tap (tap[b])
    );
  end

  // Counts fresh shifts since reset, saturating at depth.
  always_comb begin
    cnt_d = cnt_q;
    if (ce && (cnt_q < CW'(depth))) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (r) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

  assign tap_ok = (cnt_q > CW'(ea));

  if (outreg) begin : g_outreg
    logic [width-1:0] q_q;
    logic [width-1:0] q_d;
    logic             valid_q;
    logic             valid_d;

    always_comb begin
      q_d     = tap;
      valid_d = tap_ok;
    end

    always_ff @(posedge clk) begin
      if (r) begin
        q_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        q_q     <= q_d;
        valid_q <= valid_d;
      end
    end

    assign q     = q_q;
    assign valid = valid_q;
  end else begin : g_comb
    assign q     = tap;
    assign valid = tap_ok;
  end

endmodule

// File: tb/tb_srl_tap_delay.sv
// Directed bench: one combinational-output and one registered-output instance
// (width 8, depth 130) driven from shared inputs.
module tb_srl_tap_delay;

  logic       clk;
  logic       r;
  logic       ce;
  logic [7:0] i;
  logic [7:0] a;
  logic [7:0] q0, q1;
  logic       valid0, valid1;

  int tests_run;
  int tests_failed;

  srl_tap_delay #(.width(8), .depth(130), .outreg(1'b0)) u_dut0 (
    .clk(clk), .r(r), .ce(ce), .i(i), .a(a), .q(q0), .valid(valid0)
  );

  srl_tap_delay #(.width(8), .depth(130), .outreg(1'b1)) u_dut1 (
    .clk(clk), .r(r), .ce(ce), .i(i), .a(a), .q(q1), .valid(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs applied before the call are sampled on this edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r  = 1'b1;
    ce = 1'b1;
    tick();
    r  = 1'b0;
    ce = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    r  = 1'b0;
    ce = 1'b0;
    i  = 8'h00;
    a  = 8'd0;
    #2;

    // Reset state
    do_reset();
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    chk("rst_q1", 32'(q1), 32'd0);

    // Basic delay, a=0
    a = 8'd0;
    for (int n = 1; n <= 5; n++) begin
      i  = 8'(n);
      ce = 1'b1;
      tick();
      chk("basic_q0", 32'(q0), 32'(n));
      chk("basic_valid0", 32'(valid0), 32'd1);
      chk("basic_valid1", 32'(valid1), (n >= 2) ? 32'd1 : 32'd0);
      if (n >= 2) chk("basic_q1", 32'(q1), 32'(n - 1));
    end
    ce = 1'b0;

    // Enable gating, a=3
    do_reset();
    a = 8'd3;
    for (int n = 0; n < 4; n++) begin
      i  = 8'h0A + 8'(n);
      ce = 1'b1;
      tick();
      chk("gate_fill_valid0", 32'(valid0), (n == 3) ? 32'd1 : 32'd0);
    end
    ce = 1'b0;
    i  = 8'hFF;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("gate_stall_q0", 32'(q0), 32'h0A);
      chk("gate_stall_valid0", 32'(valid0), 32'd1);
      chk("gate_stall_q1", 32'(q1), 32'h0A);
      chk("gate_stall_valid1", 32'(valid1), 32'd1);
    end
    i  = 8'h0E;
    ce = 1'b1;
    tick();
    chk("gate_after_q0", 32'(q0), 32'h0B);
    chk("gate_after_q1", 32'(q1), 32'h0A);
    ce = 1'b0;
    tick();
    chk("gate_after2_q1", 32'(q1), 32'h0B);

    // Full depth, a=129, ramp i = shift_index-1
    do_reset();
    a = 8'd129;
    for (int k = 1; k <= 135; k++) begin
      i  = 8'(k - 1);
      ce = 1'b1;
      tick();
      chk("full_valid1", 32'(valid1), (k >= 131) ? 32'd1 : 32'd0);
      chk("full_valid0", 32'(valid0), (k >= 130) ? 32'd1 : 32'd0);
      if (k >= 131) chk("full_q1", 32'(q1), 32'(k - 131));
      if (k >= 130) chk("full_q0", 32'(q0), 32'(k - 130));
    end
    ce = 1'b0;

    // Clamp: 135 shifts done, stage[j] holds 134-j
    a = 8'd255;
    #1;
    chk("clamp_q0", 32'(q0), 32'd5);
    chk("clamp_valid0", 32'(valid0), 32'd1);
    tick();
    chk("clamp_q1", 32'(q1), 32'd5);
    chk("clamp_valid1", 32'(valid1), 32'd1);

    // Dynamic tap sweep with storage held
    for (int n = 0; n <= 129; n++) begin
      a = 8'(n);
      tick();
      chk("sweep_q0", 32'(q0), 32'(134 - n));
      chk("sweep_q1", 32'(q1), 32'(134 - n));
    end

    // Continue ramp to 200 total shifts
    for (int k = 136; k <= 200; k++) begin
      i  = 8'(k - 1);
      ce = 1'b1;
      tick();
    end

    // Reset mid-stream with ce high: no shift, outputs flagged stale
    a  = 8'd9;
    i  = 8'h77;
    r  = 1'b1;
    ce = 1'b1;
    tick();
    r = 1'b0;
    chk("mid_valid0", 32'(valid0), 32'd0);
    chk("mid_valid1", 32'(valid1), 32'd0);
    chk("mid_q1", 32'(q1), 32'd0);
    chk("mid_noshift_q0", 32'(q0), 32'd190);
    for (int n = 1; n <= 11; n++) begin
      i  = 8'h80 + 8'(n);
      ce = 1'b1;
      tick();
      chk("mid_refill_valid0", 32'(valid0), (n >= 10) ? 32'd1 : 32'd0);
      chk("mid_refill_valid1", 32'(valid1), (n >= 11) ? 32'd1 : 32'd0);
      if (n >= 10) chk("mid_refill_q0", 32'(q0), 32'(8'h80 + 8'(n - 9)));
      if (n >= 11) chk("mid_refill_q1", 32'(q1), 32'(8'h80 + 8'(n - 10)));
    end
    ce = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
